kim_stream_gen: RTL and testbench

Programmable valid/ready stream source that drives the slave side of the FIFO (`s_valid`/`s_ready`/`s_data`) with a burst of arithmetic-sequence data words. It is the producer end of the FIFO's streaming protocol and serves both as a bring-up traffic source and as a building block for DMA-style writers. The controller pulses `start`, the block emits `burst_len` beats, and then it pulses `done`.

---
 rtl/kim_stream_gen_if.sv | 11 +
 rtl/kim_stream_gen.sv | 128 ++++++++++++
 tb/tb_kim_stream_gen.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/kim_stream_gen_if.sv
// Valid/ready stream bundle between kim_stream_gen and a FIFO slave port.
interface kim_stream_gen_if #(
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/kim_stream_gen.sv
// Burst stream source emitting an arithmetic sequence on a valid/ready port.
// Optional inter-beat throttle (GAP state) enabled by KIM_STREAM_GEN_THROTTLE_EN.
module kim_stream_gen #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8,
  parameter int GAP_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  burst_len_i,
  input  logic [DATA_W-1:0] seed_i,
  input  logic [DATA_W-1:0] step_i,
  input  logic [GAP_W-1:0]  gap_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [LEN_W-1:0]  beat_cnt_o,
  kim_stream_gen_if.master  m_if
);

`ifdef KIM_STREAM_GEN_THROTTLE_EN
  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;
`else
  typedef enum logic [0:0] {IDLE, RUN} state_t;
`endif

  state_t            state_q;
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              busy_q;
  logic              done_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] step_q;
  logic [LEN_W-1:0]  cnt_inc;

`ifdef KIM_STREAM_GEN_THROTTLE_EN
  logic [GAP_W-1:0]  gap_q;
  logic [GAP_W-1:0]  gap_cnt_q;
`else
  logic              unused_gap;
  assign unused_gap = ^gap_i;
`endif

  assign cnt_inc = cnt_q + LEN_W'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      len_q     <= '0;
      step_q    <= '0;
`ifdef KIM_STREAM_GEN_THROTTLE_EN
      gap_q     <= '0;
      gap_cnt_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (start_i) begin
            len_q  <= burst_len_i;
            step_q <= step_i;
            cnt_q  <= '0;
`ifdef KIM_STREAM_GEN_THROTTLE_EN
            gap_q  <= gap_i;
`endif
            // Zero-length burst completes without ever raising valid
            if (burst_len_i == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= RUN;
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
              data_q  <= seed_i;
            end
          end
        end
        RUN: begin
          if (valid_q && m_if.ready) begin
            cnt_q  <= cnt_inc;
            data_q <= data_q + step_q;
            if (cnt_inc == len_q) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
`ifdef KIM_STREAM_GEN_THROTTLE_EN
            else if (gap_q != '0) begin
              state_q   <= GAP;
              valid_q   <= 1'b0;
              gap_cnt_q <= gap_q;
            end
`endif
          end
        end
`ifdef KIM_STREAM_GEN_THROTTLE_EN
        GAP: begin
          // Terminal count at 1 yields exactly gap_q idle cycles
          gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          if (gap_cnt_q == GAP_W'(1)) begin
            state_q <= RUN;
            valid_q <= 1'b1;
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign m_if.valid = valid_q;
  assign m_if.data  = data_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign beat_cnt_o = cnt_q;

endmodule

// File: tb/tb_kim_stream_gen.sv
// Randomized self-checking bench for kim_stream_gen against a beat-index reference model.
module tb_kim_stream_gen;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;
  localparam int GAP_W  = 4;
`ifdef KIM_STREAM_GEN_THROTTLE_EN
  localparam bit THR = 1'b1;
`else
  localparam bit THR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [LEN_W-1:0]  burst_len;
  logic [DATA_W-1:0] seed;
  logic [DATA_W-1:0] step;
  logic [GAP_W-1:0]  gap;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  beat_cnt;

  always #5 clk = ~clk;

  kim_stream_gen_if #(.DATA_W(DATA_W)) s_if ();

  kim_stream_gen #(.DATA_W(DATA_W), .LEN_W(LEN_W), .GAP_W(GAP_W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .burst_len_i (burst_len),
    .seed_i      (seed),
    .step_i      (step),
    .gap_i       (gap),
    .busy_o      (busy),
    .done_o      (done),
    .beat_cnt_o  (beat_cnt),
    .m_if        (s_if)
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [63:0] vpat;
  int          vlen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Config inputs change freely mid-burst; only an accepted start may latch them
  task automatic scramble_cfg();
    burst_len = LEN_W'($urandom);
    seed      = $urandom;
    step      = $urandom;
    gap       = GAP_W'($urandom);
  endtask

  task automatic drive_ready(input int mode, input int k, inout int stalls);
    case (mode)
      0: s_if.ready = 1'b1;
      1: s_if.ready = ($urandom_range(0, 99) < 70);
      default: begin
        if (k == 1 && stalls < 3) begin
          s_if.ready = 1'b0;
          stalls++;
        end else begin
          s_if.ready = 1'b1;
        end
      end
    endcase
  endtask

  // Expected beat k carries seed + k*step; after each non-last beat, gap idle cycles (throttle only)
  task automatic run_burst(input int len, input logic [31:0] sd, input logic [31:0] st,
                           input int g, input int rmode, input bit immediate, input bit mid_start);
    int          k = 0;
    int          idle_left = 0;
    int          cyc = 0;
    int          stalls = 0;
    bit          fin = 1'b0;
    logic [31:0] expd;
    if (!immediate) begin
      @(posedge clk); #1;
    end
    start     = 1'b1;
    burst_len = LEN_W'(len);
    seed      = sd;
    step      = st;
    gap       = GAP_W'(g);
    @(posedge clk); #1;
    start = 1'b0;
    scramble_cfg();
    drive_ready(rmode, k, stalls);
    vpat = '0;
    vlen = 0;
    while (!fin && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (k == len) begin
        chk("done_pulse", 64'(done), 64'd1);
        chk("done_valid", 64'(s_if.valid), 64'd0);
        chk("done_busy", 64'(busy), 64'd0);
        chk("done_cnt", 64'(beat_cnt), 64'(len));
        fin = 1'b1;
      end else begin
        chk("done_early", 64'(done), 64'd0);
        chk("busy", 64'(busy), 64'd1);
        chk("beat_cnt", 64'(beat_cnt), 64'(k));
        vpat = {vpat[62:0], s_if.valid};
        vlen++;
        if (idle_left > 0) begin
          chk("gap_valid", 64'(s_if.valid), 64'd0);
          idle_left--;
        end else begin
          expd = sd + st * 32'(k);
          chk("valid", 64'(s_if.valid), 64'd1);
          chk("data", 64'(s_if.data), 64'(expd));
          if (s_if.ready) begin
            k++;
            if (k < len && THR) idle_left = g;
          end
        end
        @(posedge clk); #1;
        if (mid_start) start = (cyc == 2);
        scramble_cfg();
        drive_ready(rmode, k, stalls);
      end
    end
    if (!fin) chk("timeout", 64'd0, 64'd1);
  endtask

  task automatic idle_after(input int len);
    @(negedge clk);
    chk("post_done", 64'(done), 64'd0);
    chk("post_valid", 64'(s_if.valid), 64'd0);
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_cnt", 64'(beat_cnt), 64'(len));
  endtask

  initial begin
    bit chain;
    int len;
    rst_n      = 1'b0;
    start      = 1'b0;
    s_if.ready = 1'b0;
    burst_len  = '0;
    seed       = '0;
    step       = '0;
    gap        = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(s_if.valid), 64'd0);
    chk("rst_data", 64'(s_if.data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_cnt", 64'(beat_cnt), 64'd0);
    rst_n = 1'b1;

    run_burst(4, 32'h10, 32'd4, 0, 0, 1'b0, 1'b0);
    chk("basic_vlen", 64'(vlen), 64'd4);
    idle_after(4);

    run_burst(4, 32'h10, 32'd4, 0, 2, 1'b0, 1'b0);
    chk("stall_vlen", 64'(vlen), 64'd7);
    idle_after(4);

    run_burst(3, 32'hFFFF_FFFE, 32'd1, 0, 0, 1'b0, 1'b0);
    idle_after(3);

    run_burst(0, 32'h1234, 32'd1, 0, 0, 1'b0, 1'b0);
    chk("zero_vlen", 64'(vlen), 64'd0);
    idle_after(0);

    run_burst(3, 32'h100, 32'h10, 2, 0, 1'b0, 1'b0);
    chk("thr_pattern", vpat, THR ? 64'h49 : 64'h7);
    chk("thr_vlen", 64'(vlen), THR ? 64'd7 : 64'd3);
    idle_after(3);

    run_burst(6, 32'h55, 32'd3, 0, 0, 1'b0, 1'b1);
    chk("busy_start_vlen", 64'(vlen), 64'd6);
    run_burst(3, 32'hA0, 32'd1, 1, 1, 1'b1, 1'b0);
    idle_after(3);

    @(posedge clk); #1;
    start      = 1'b1;
    burst_len  = 8'd5;
    seed       = 32'h200;
    step       = 32'd2;
    gap        = '0;
    s_if.ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("mid_b0", 64'(s_if.data), 64'h200);
    @(negedge clk);
    chk("mid_b1", 64'(s_if.data), 64'h202);
    @(negedge clk);
    chk("mid_cnt2", 64'(beat_cnt), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(s_if.valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_cnt", 64'(beat_cnt), 64'd0);
    chk("arst_data", 64'(s_if.data), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("arst_done", 64'(done), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_done", 64'(done), 64'd0);
    chk("rel_busy", 64'(busy), 64'd0);
    run_burst(2, 32'h300, 32'd5, 0, 0, 1'b0, 1'b0);
    idle_after(2);

    chain = 1'b0;
    for (int i = 0; i < 25; i++) begin
      len = $urandom_range(0, 10);
      run_burst(len, $urandom, $urandom, $urandom_range(0, 3), 1, chain, 1'b0);
      chain = (i < 24) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (!chain) idle_after(len);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
